// File: rtl/disp_chan_arb.sv
// Display channel arbiter: round-robin grant of 8 request lines with a minimum hold time and a manual override.
// Optional build macro DISP_AUTOSCAN_EN: while idle with no requests, step ch_sel through the channels every HOLD_CNT cycles.
module disp_chan_arb #(
    parameter int                HOLD_W   = 24,
    parameter logic [HOLD_W-1:0] HOLD_CNT = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       manual,
    input  logic [2:0] man_sel,
    output logic [2:0] ch_sel,
    output logic [7:0] grant,
    output logic       ch_valid,
    output logic       hold_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        MANUAL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        ch_sel_q, ch_sel_d;
    logic [7:0]        grant_q, grant_d;
    logic              ch_valid_q, ch_valid_d;
    logic              hold_done_q, hold_done_d;

    logic [3:0]        pick;
    logic              rearb;

    // Returns {found, index} of the first set request bit after position p, wrapping 7->0.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = p + 3'(k);
            if (!res[3] && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

    assign pick  = rr_pick(req, ptr_q);
    assign rearb = (state_q == IDLE) || ((state_q == HOLD) && (cnt_q == '0));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        ch_sel_d    = ch_sel_q;
        grant_d     = grant_q;
        ch_valid_d  = ch_valid_q;
        hold_done_d = 1'b0;

        if (manual) begin
            // Override wins over any hold in progress; the aborted hold never reports done.
            state_d    = MANUAL;
            ch_sel_d   = man_sel;
            grant_d    = onehot(man_sel);
            ch_valid_d = 1'b1;
            cnt_d      = '0;
        end else if (state_q == MANUAL) begin
            state_d    = IDLE;
            ptr_d      = man_sel;
            grant_d    = 8'h00;
            ch_valid_d = 1'b0;
            cnt_d      = '0;
        end else if (state_q == HOLD && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (rearb) begin
            hold_done_d = (state_q == HOLD);
            if (pick[3]) begin
                state_d    = HOLD;
                ch_sel_d   = pick[2:0];
                ptr_d      = pick[2:0];
                grant_d    = onehot(pick[2:0]);
                ch_valid_d = 1'b1;
                cnt_d      = HOLD_CNT - 1'b1;
            end else begin
                state_d    = IDLE;
                grant_d    = 8'h00;
                ch_valid_d = 1'b0;
`ifdef DISP_AUTOSCAN_EN
                // Idle scan reuses the hold counter as an up-counter; the IDLE->HOLD load resets its meaning.
                if (state_q == IDLE && cnt_q >= HOLD_CNT - 1'b1) begin
                    cnt_d       = '0;
                    ch_sel_d    = ch_sel_q + 3'd1;
                    hold_done_d = 1'b1;
                end else if (state_q == IDLE) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                end
`else
                cnt_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= 3'd7;
            ch_sel_q    <= 3'd0;
            grant_q     <= 8'h00;
            ch_valid_q  <= 1'b0;
            hold_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            ch_sel_q    <= ch_sel_d;
            grant_q     <= grant_d;
            ch_valid_q  <= ch_valid_d;
            hold_done_q <= hold_done_d;
        end
    end

    assign ch_sel    = ch_sel_q;
    assign grant     = grant_q;
    assign ch_valid  = ch_valid_q;
    assign hold_done = hold_done_q;

endmodule

// File: tb/tb_disp_chan_arb.sv
// Directed bench for disp_chan_arb with HOLD_CNT=4; expected outputs are queued as each step is driven.
module tb_disp_chan_arb;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       manual;
    logic [2:0] man_sel;
    logic [2:0] ch_sel;
    logic [7:0] grant;
    logic       ch_valid;
    logic       hold_done;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic [12:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];

    disp_chan_arb #(
        .HOLD_W  (8),
        .HOLD_CNT(8'd4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .manual   (manual),
        .man_sel  (man_sel),
        .ch_sel   (ch_sel),
        .grant    (grant),
        .ch_valid (ch_valid),
        .hold_done(hold_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive inputs, queue the outputs expected after the edge, then compare.
    task automatic c(input logic r, input logic [7:0] rq, input logic m, input logic [2:0] ms,
                     input logic [7:0] eg, input logic [2:0] es, input logic ev, input logic ed,
                     input string tag);
        exp_t        e;
        logic [12:0] obs;
        rst     = r;
        req     = rq;
        manual  = m;
        man_sel = ms;
        sb.push_back('{v: {eg, es, ev, ed}, tag: tag});
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        obs = {grant, ch_sel, ch_valid, hold_done};
        vectors++;
        assert (obs === e.v) else begin
            miscompares++;
            $error("FAIL %s: observed grant/sel/vld/done=%h expected %h", e.tag, obs, e.v);
        end
    endtask

    initial begin
        c(1, 8'h00, 0, 0, 8'h00, 0, 0, 0, "reset");
        c(1, 8'hFF, 1, 5, 8'h00, 0, 0, 0, "reset_overrides");
`ifdef DISP_AUTOSCAN_EN
        for (int k = 1; k <= 12; k++) begin
            c(0, 8'h00, 0, 0, 8'h00, 3'(k / 4), 0, (k % 4 == 0), "autoscan");
        end
`else
        // First grant and hold_done timing
        c(0, 8'h01, 0, 0, 8'h01, 0, 1, 0, "first_grant");
        c(0, 8'h01, 0, 0, 8'h01, 0, 1, 0, "hold1");
        c(0, 8'h01, 0, 0, 8'h01, 0, 1, 0, "hold2");
        c(0, 8'h01, 0, 0, 8'h01, 0, 1, 0, "hold3");
        c(0, 8'h01, 0, 0, 8'h01, 0, 1, 1, "regrant_same_done");
        c(0, 8'h00, 0, 0, 8'h01, 0, 1, 0, "hold_no_req1");
        c(0, 8'h00, 0, 0, 8'h01, 0, 1, 0, "hold_no_req2");
        c(0, 8'h00, 0, 0, 8'h01, 0, 1, 0, "hold_no_req3");
        c(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, "to_idle");
        c(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, "idle_freeze");
        // Request drops right after grant on channel 2
        c(0, 8'h04, 0, 0, 8'h04, 2, 1, 0, "grant_ch2");
        c(0, 8'h00, 0, 0, 8'h04, 2, 1, 0, "min_hold1");
        c(0, 8'h00, 0, 0, 8'h04, 2, 1, 0, "min_hold2");
        c(0, 8'h00, 0, 0, 8'h04, 2, 1, 0, "min_hold3");
        c(0, 8'h00, 0, 0, 8'h00, 2, 0, 1, "idle_keep_sel");
        c(0, 8'h00, 0, 0, 8'h00, 2, 0, 0, "idle_keep_sel2");
        // Round-robin alternation from ptr=2 with req=84
        c(0, 8'h84, 0, 0, 8'h80, 7, 1, 0, "rr_ch7");
        c(0, 8'h84, 0, 0, 8'h80, 7, 1, 0, "rr_ch7_h1");
        c(0, 8'h84, 0, 0, 8'h80, 7, 1, 0, "rr_ch7_h2");
        c(0, 8'h84, 0, 0, 8'h80, 7, 1, 0, "rr_ch7_h3");
        c(0, 8'h84, 0, 0, 8'h04, 2, 1, 1, "rr_wrap_ch2");
        c(0, 8'h84, 0, 0, 8'h04, 2, 1, 0, "rr_ch2_h1");
        c(0, 8'h84, 0, 0, 8'h04, 2, 1, 0, "rr_ch2_h2");
        c(0, 8'h84, 0, 0, 8'h04, 2, 1, 0, "rr_ch2_h3");
        c(0, 8'h84, 0, 0, 8'h80, 7, 1, 1, "rr_ch7_again");
        // Manual override mid-hold, then release
        c(0, 8'h84, 1, 5, 8'h20, 5, 1, 0, "manual_enter");
        c(0, 8'h84, 1, 5, 8'h20, 5, 1, 0, "manual_stay");
        c(0, 8'h84, 1, 3, 8'h08, 3, 1, 0, "manual_follow");
        c(0, 8'h84, 1, 5, 8'h20, 5, 1, 0, "manual_back5");
        c(0, 8'h84, 0, 5, 8'h00, 5, 0, 0, "manual_release");
        c(0, 8'h84, 0, 5, 8'h80, 7, 1, 0, "search_from_6");
        // Reset mid-hold with every channel requesting
        c(0, 8'hFF, 0, 0, 8'h80, 7, 1, 0, "hold_ff");
        c(1, 8'hFF, 0, 0, 8'h00, 0, 0, 0, "reset_mid_hold");
        c(0, 8'hFF, 0, 0, 8'h01, 0, 1, 0, "post_reset_grant");
        c(0, 8'h00, 1, 6, 8'h40, 6, 1, 0, "manual_from_hold");
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
